ir_fetch: RTL and testbench
===========================

# ir_fetch

Instruction fetch sequencer downstream of `ir_decoder_load` and the IR register file it fills. Once a program is loaded, `ir_fetch` keeps a program counter and reads one instruction per step from the IR register file. It presents each instruction to the decoder with a valid/ready handshake and applies sequential, jump and halt updates to the PC. It never reads while the loader reports busy, so fetches and load writes cannot interleave.

## Interface
- `DATA_WIDTH`, 8, width of PC, IR addresses and instruction words (equal to the shared `DATA_WIDTH`).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_start_pc`  in  DATA_WIDTH  first instruction address, captured with `i_start`.
- `i_load_busy`  in  1  loader busy (loader `o_busy`); blocks new reads.
- `i_ir_data`  in  DATA_WIDTH  IR register file read data; valid 1 cycle after `o_ir_ren`.
- `i_dec_ready`  in  1  decoder accepts `o_instr` this cycle.
- `i_jump`  in  1  with accept: next PC is `i_jump_pc`.
- `i_jump_pc`  in  DATA_WIDTH  jump target.
- `i_halt`  in  1  with accept: stop fetching, return to IDLE.
- `o_ir_ren`  out  1  IR register file read enable, one-cycle pulse.
- `o_ir_raddr`  out  DATA_WIDTH  IR read address (= PC during read).
- `o_instr`  out  DATA_WIDTH  registered instruction word.
- `o_instr_valid`  out  1  `o_instr` valid for the decoder.
- `o_pc`  out  DATA_WIDTH  address of the instruction currently in `o_instr`.
- `o_busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, WAIT_LOAD, REQ, DATA, VALID.
- **IDLE**
  - On `i_start`: `pc <= i_start_pc`.
  - Go to WAIT_LOAD if `i_load_busy`, otherwise go to REQ.
  - Without `i_start`, stay in IDLE.
- **WAIT_LOAD**: hold while `i_load_busy`; go to REQ the first cycle it is low.
- **REQ**: `o_ir_ren=1`, `o_ir_raddr=pc`; go to DATA unconditionally.
- **DATA**: `instr <= i_ir_data`, `o_pc` reg `<= pc`; go to VALID.
- **VALID**
  - `o_instr_valid=1`; `o_instr` and `o_pc` are held stable until accepted.
  - Accept (`i_dec_ready=1`) next-PC priority: `i_halt` → IDLE (PC unchanged); else `i_jump` → `pc <= i_jump_pc`; else `pc <= pc + 1`.
  - After a non-halt accept, go to WAIT_LOAD if `i_load_busy`, otherwise go to REQ.
- PC arithmetic is modulo 2^DATA_WIDTH: `pc+1` from 8'hFF wraps to 8'h00 with no flag.
- `i_jump` and `i_halt` are ignored outside an accepting VALID cycle.
- `i_start` is ignored outside IDLE; there is no restart mid-program.
- `i_load_busy` is only checked on entry to REQ. A read already issued in REQ always completes through DATA and VALID.

## Timing
- Reset values: state IDLE; `pc`, `o_pc`, `o_instr` = 0; `o_ir_ren`, `o_instr_valid`, `o_busy` = 0.
- Reset mid-operation returns to IDLE next edge. An instruction being presented is dropped and not replayed.
- `o_ir_ren` and `o_instr_valid` are decoded from the registered state and do not depend combinationally on inputs.
- Start latency (load idle): `i_start` in cycle 0, REQ in cycle 1, DATA in cycle 2, `o_instr_valid` in cycle 3.
- Steady state with `i_dec_ready` held high: one instruction every 3 cycles, and `o_instr_valid` is high 1 of every 3 cycles.
- Decoder back-pressure stretches VALID indefinitely; no instruction is lost or duplicated.
- `i_halt` and `i_jump` together on accept: halt wins.

## Structure
- A shared package/include holds:
  - `DATA_WIDTH`;
  - the IR_FETCH state encodings (3-bit, beside the loader's state defines, with distinct macro names);
  - `IR_RESET_PC` (0).
- Single module, no sub-module. PC, instruction register and FSM are inline.

## Test plan
- Reset then idle: all outputs 0 and `o_busy=0` for 10 cycles with no `i_start`.
- Sequential fetch: IR[0x10..0x12] = A1, B2, C3; start at 0x10 with `i_dec_ready=1` → `o_instr` A1/B2/C3 with `o_pc` 0x10/0x11/0x12; first valid 3 cycles after start; `i_halt` on C3 → IDLE, `o_busy=0`.
- Back-pressure: hold `i_dec_ready=0` for 5 cycles in VALID → `o_instr` and `o_pc` stable, `o_ir_ren=0`; release → next read at PC+1.
- Jump/halt priority:
  - Jump to 0x40 on accept → next `o_ir_raddr=0x40`.
  - `i_jump` and `i_halt` together → IDLE, no further reads.
- Load interlock:
  - `i_load_busy=1` at start → stays in WAIT_LOAD with no `o_ir_ren` until busy drops, then REQ next cycle.
  - Busy asserted during DATA → current instruction still delivered; next read deferred.
- Wrap and reset: start at 0xFF → `o_pc` 0xFF then 0x00. Assert `rst` in VALID → IDLE next edge, `o_instr_valid=0`.

Source files
------------

// File: rtl/ir_fetch_pkg.sv
// ir_fetch_pkg: shared definitions for the instruction fetch sequencer.
//   DATA_WIDTH    - width of PC, IR addresses and instruction words
//   IR_RESET_PC   - program counter value after reset
//   fetch_state_t - 3-bit fetch FSM encoding (FETCH_* names stay clear of
//                   the loader's own state names)
package ir_fetch_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int IR_RESET_PC = 0;

  typedef enum logic [2:0] {
    FETCH_IDLE      = 3'd0,
    FETCH_WAIT_LOAD = 3'd1,
    FETCH_REQ       = 3'd2,
    FETCH_DATA      = 3'd3,
    FETCH_VALID     = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/ir_fetch.sv
// ir_fetch: instruction fetch sequencer.
// Keeps a program counter, reads one instruction per step from the IR
// register file and presents it to the decoder with a valid/ready handshake.
// Never issues a read while the loader is busy.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   i_start        start request (IDLE only), with i_start_pc first address
//   i_load_busy    loader busy; defers entry to REQ
//   i_ir_data      IR read data, valid one cycle after o_ir_ren
//   i_dec_ready    decoder accepts o_instr this cycle
//   i_jump/_pc     on accept: next PC is i_jump_pc
//   i_halt         on accept: stop fetching (wins over i_jump)
//   o_ir_ren       IR read enable pulse, o_ir_raddr = PC
//   o_instr        registered instruction, o_pc its address
//   o_instr_valid  instruction presented to the decoder
//   o_busy         high outside IDLE
module ir_fetch
  import ir_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = ir_fetch_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_start_pc,
  input  logic                  i_load_busy,
  input  logic [DATA_WIDTH-1:0] i_ir_data,
  input  logic                  i_dec_ready,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_jump_pc,
  input  logic                  i_halt,
  output logic                  o_ir_ren,
  output logic [DATA_WIDTH-1:0] o_ir_raddr,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic                  o_instr_valid,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_busy
);

  localparam logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(IR_RESET_PC);
  localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(1);

  fetch_state_t          state, state_next;
  logic [DATA_WIDTH-1:0] pc, pc_next;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] instr_pc;

  wire accept = (state == FETCH_VALID) && i_dec_ready;

  // Next-state and PC update
  always_comb begin
    state_next = state;
    pc_next    = pc;
    unique case (state)
      FETCH_IDLE: begin
        if (i_start) begin
          pc_next    = i_start_pc;
          state_next = i_load_busy ? FETCH_WAIT_LOAD : FETCH_REQ;
        end
      end
      FETCH_WAIT_LOAD: begin
        if (!i_load_busy) state_next = FETCH_REQ;
      end
      FETCH_REQ:  state_next = FETCH_DATA;
      FETCH_DATA: state_next = FETCH_VALID;
      FETCH_VALID: begin
        if (accept) begin
          // Halt leaves PC untouched and beats a simultaneous jump.
          if (i_halt) begin
            state_next = FETCH_IDLE;
          end else begin
            pc_next    = i_jump ? i_jump_pc : pc + PC_STEP;
            state_next = i_load_busy ? FETCH_WAIT_LOAD : FETCH_REQ;
          end
        end
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  // State and PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Instruction capture: read data lands during DATA and is held through VALID
  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= '0;
      instr_pc <= '0;
    end else if (state == FETCH_DATA) begin
      instr    <= i_ir_data;
      instr_pc <= pc;
    end
  end

  // Outputs decode from registered state only
  assign o_ir_ren      = (state == FETCH_REQ);
  assign o_ir_raddr    = pc;
  assign o_instr       = instr;
  assign o_pc          = instr_pc;
  assign o_instr_valid = (state == FETCH_VALID);
  assign o_busy        = (state != FETCH_IDLE);

endmodule

// File: tb/tb_ir_fetch.sv
module tb_ir_fetch;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [W-1:0] i_start_pc;
  logic         i_load_busy;
  logic [W-1:0] i_ir_data;
  logic         i_dec_ready;
  logic         i_jump;
  logic [W-1:0] i_jump_pc;
  logic         i_halt;
  logic         o_ir_ren;
  logic [W-1:0] o_ir_raddr;
  logic [W-1:0] o_instr;
  logic         o_instr_valid;
  logic [W-1:0] o_pc;
  logic         o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] ir_mem [256];
  logic [2*W-1:0] sb_q [$];

  always #5 clk = ~clk;

  ir_fetch #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_start_pc    (i_start_pc),
    .i_load_busy   (i_load_busy),
    .i_ir_data     (i_ir_data),
    .i_dec_ready   (i_dec_ready),
    .i_jump        (i_jump),
    .i_jump_pc     (i_jump_pc),
    .i_halt        (i_halt),
    .o_ir_ren      (o_ir_ren),
    .o_ir_raddr    (o_ir_raddr),
    .o_instr       (o_instr),
    .o_instr_valid (o_instr_valid),
    .o_pc          (o_pc),
    .o_busy        (o_busy)
  );

  // IR register file model: synchronous read, data one cycle after enable
  always @(posedge clk) begin
    if (o_ir_ren) i_ir_data <= ir_mem[o_ir_raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake the decoder completes must match the next
  // expected {instr, pc} pair pushed by the stimulus.
  always @(negedge clk) begin
    if (!rst && o_instr_valid && i_dec_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_instr", {o_instr, o_pc}, 32'hFFFF_FFFF);
      end else begin
        logic [2*W-1:0] e;
        e = sb_q.pop_front();
        check("sb_instr", {24'h0, o_instr}, {24'h0, e[2*W-1:W]});
        check("sb_pc", {24'h0, o_pc}, {24'h0, e[W-1:0]});
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pair(input logic [W-1:0] ins, input logic [W-1:0] pc);
    sb_q.push_back({ins, pc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ir_mem[i] = 8'h00;
    ir_mem[8'h10] = 8'hA1; ir_mem[8'h11] = 8'hB2; ir_mem[8'h12] = 8'hC3;
    ir_mem[8'h20] = 8'h5A; ir_mem[8'h21] = 8'h6B;
    ir_mem[8'h30] = 8'h11; ir_mem[8'h40] = 8'h22;
    ir_mem[8'h60] = 8'h77; ir_mem[8'h61] = 8'h88;
    ir_mem[8'hFF] = 8'hEE; ir_mem[8'h00] = 8'hDD;

    rst = 1'b1; i_start = 1'b0; i_start_pc = '0; i_load_busy = 1'b0;
    i_ir_data = '0; i_dec_ready = 1'b0; i_jump = 1'b0; i_jump_pc = '0; i_halt = 1'b0;
    step(2);
    rst = 1'b0;

    // Reset then idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      check("idle_outputs", {o_ir_ren, o_instr_valid, o_busy, o_instr, o_pc, o_ir_raddr}, 32'h0);
      step();
    end

    // Sequential fetch A1/B2/C3, halt on C3
    expect_pair(8'hA1, 8'h10); expect_pair(8'hB2, 8'h11); expect_pair(8'hC3, 8'h12);
    i_dec_ready = 1'b1; i_start = 1'b1; i_start_pc = 8'h10;
    step();
    i_start = 1'b0;
    check("seq_req_ren", o_ir_ren, 1);
    check("seq_req_addr", o_ir_raddr, 8'h10);
    check("seq_req_busy", o_busy, 1);
    step();
    check("seq_data_valid", o_instr_valid, 0);
    step();
    check("seq_first_valid", o_instr_valid, 1);
    step(3);
    check("seq_second_valid", {o_instr_valid, o_pc}, {1'b1, 8'h11});
    step(3);
    check("seq_third_valid", {o_instr_valid, o_pc}, {1'b1, 8'h12});
    i_halt = 1'b1;
    step();
    i_halt = 1'b0;
    check("seq_halt_busy", o_busy, 0);
    for (int i = 0; i < 3; i++) begin
      check("seq_halt_no_ren", o_ir_ren, 0);
      step();
    end

    // Back-pressure: hold ready low in VALID for 5 cycles
    expect_pair(8'h5A, 8'h20); expect_pair(8'h6B, 8'h21);
    i_dec_ready = 1'b0; i_start = 1'b1; i_start_pc = 8'h20;
    step();
    i_start = 1'b0;
    step(2);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {o_instr_valid, o_ir_ren, o_instr, o_pc}, {1'b1, 1'b0, 8'h5A, 8'h20});
      step();
    end
    i_dec_ready = 1'b1;
    step();
    check("bp_next_ren", o_ir_ren, 1);
    check("bp_next_addr", o_ir_raddr, 8'h21);
    step(2);
    check("bp_second_valid", o_instr_valid, 1);
    i_halt = 1'b1;
    step();
    i_halt = 1'b0;

    // Jump, then jump+halt together
    expect_pair(8'h11, 8'h30); expect_pair(8'h22, 8'h40);
    i_start = 1'b1; i_start_pc = 8'h30;
    step();
    i_start = 1'b0;
    step(2);
    check("jmp_valid", o_instr_valid, 1);
    i_jump = 1'b1; i_jump_pc = 8'h40;
    step();
    i_jump = 1'b0;
    check("jmp_ren", o_ir_ren, 1);
    check("jmp_addr", o_ir_raddr, 8'h40);
    step(2);
    check("jmp_target_valid", o_instr_valid, 1);
    i_jump = 1'b1; i_jump_pc = 8'h50; i_halt = 1'b1;
    step();
    i_jump = 1'b0; i_halt = 1'b0;
    check("jh_busy", o_busy, 0);
    for (int i = 0; i < 4; i++) begin
      check("jh_no_ren", o_ir_ren, 0);
      step();
    end

    // Load interlock at start and during DATA
    expect_pair(8'h77, 8'h60); expect_pair(8'h88, 8'h61);
    i_load_busy = 1'b1; i_start = 1'b1; i_start_pc = 8'h60;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("wl_hold", {o_busy, o_ir_ren}, {1'b1, 1'b0});
      step();
    end
    i_load_busy = 1'b0;
    step();
    check("wl_req_ren", o_ir_ren, 1);
    check("wl_req_addr", o_ir_raddr, 8'h60);
    step();
    i_load_busy = 1'b1;
    step();
    check("wl_data_delivered", {o_instr_valid, o_instr}, {1'b1, 8'h77});
    step();
    check("wl_deferred", {o_busy, o_ir_ren, o_instr_valid}, {1'b1, 1'b0, 1'b0});
    step();
    check("wl_deferred2", o_ir_ren, 0);
    i_load_busy = 1'b0;
    step();
    check("wl_resume_ren", o_ir_ren, 1);
    check("wl_resume_addr", o_ir_raddr, 8'h61);
    step(2);
    i_halt = 1'b1;
    step();
    i_halt = 1'b0;

    // PC wrap, then reset while presenting an instruction
    expect_pair(8'hEE, 8'hFF);
    i_start = 1'b1; i_start_pc = 8'hFF;
    step();
    i_start = 1'b0;
    step(2);
    check("wrap_first", {o_instr_valid, o_pc}, {1'b1, 8'hFF});
    step();
    i_dec_ready = 1'b0;
    check("wrap_addr", o_ir_raddr, 8'h00);
    step(2);
    check("wrap_second", {o_instr_valid, o_instr, o_pc}, {1'b1, 8'hDD, 8'h00});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_valid", {o_instr_valid, o_busy, o_ir_ren}, 3'b000);
    check("rst_regs", {o_instr, o_pc}, 16'h0000);
    step(3);
    check("rst_stays_idle", {o_instr_valid, o_busy, o_ir_ren}, 3'b000);

    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
